// File: rtl/snn_interfaces_pkg.sv
// Shared types and default sizes for the feature-map pool scanner.
// Holds coordinate/event structs and the pool FSM state encoding.
// Optional spike counter in the scanner is enabled by FM_POOL_SPIKE_COUNT_EN.
package snn_interfaces_pkg;

  localparam int DEFAULT_COORD_BITS  = 4;
  localparam int DEFAULT_CHANNELS    = 2;
  localparam int DEFAULT_NEURON_BITS = 8;
  localparam int DEFAULT_IMG_WIDTH   = 4;
  localparam int DEFAULT_IMG_HEIGHT  = 4;

  typedef struct packed {
    logic [DEFAULT_COORD_BITS-1:0] x;
    logic [DEFAULT_COORD_BITS-1:0] y;
  } vec2_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    EMIT,
    NEXT,
    DONE
  } pool_state_e;

  typedef struct packed {
    vec2_t                       coord;
    logic [DEFAULT_CHANNELS-1:0] mask;
  } spike_evt_t;

endpackage

// File: rtl/fm_leak_fire.sv
// One-channel leak and threshold: saturating subtract, then fire-and-reset.
// Latency: purely combinational.
// Backpressure: none, the caller registers the result.
module fm_leak_fire #(
  parameter int B = 8
) (
  input  logic [B-1:0] v,
  input  logic [B-1:0] leak,
  input  logic [B-1:0] thresh,
  output logic [B-1:0] v_new,
  output logic         fire
);

  logic [B-1:0] leaked;

  // Leak clamps at zero so a small potential never wraps to a large one.
  always_comb begin
    leaked = (v > leak) ? (v - leak) : '0;
    fire   = (leaked >= thresh);
    v_new  = fire ? '0 : leaked;
  end

endmodule

// File: rtl/fm_pool_scanner.sv
// Pool-phase sweep of the membrane map: read, leak/fire, write back, emit events.
// Latency: 4 cycles per coordinate with no stalls, plus 1 when an event is emitted.
// Backpressure: each request (read, write, event) is held stable until its ready.
// Optional FM_POOL_SPIKE_COUNT_EN adds a spike_count output summing fired channels.
module fm_pool_scanner
  import snn_interfaces_pkg::*;
#(
  parameter int COORD_BITS       = DEFAULT_COORD_BITS,
  parameter int CHANNELS         = DEFAULT_CHANNELS,
  parameter int BITS_PER_CHANNEL = DEFAULT_NEURON_BITS,
  parameter int IMG_WIDTH        = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT       = DEFAULT_IMG_HEIGHT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [BITS_PER_CHANNEL-1:0]          cfg_leak,
  input  logic [BITS_PER_CHANNEL-1:0]          cfg_thresh,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rd_req,
  output vec2_t                                rd_coord,
  input  logic                                 rd_ready,
  input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] rd_data,
  output logic                                 wr_req,
  output vec2_t                                wr_coord,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0] wr_data,
  input  logic                                 wr_ready,
  output logic                                 evt_valid,
  input  logic                                 evt_ready,
  output vec2_t                                evt_coord,
`ifdef FM_POOL_SPIKE_COUNT_EN
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT*CHANNELS+1)-1:0] spike_count,
`endif
  output logic [CHANNELS-1:0]                  evt_mask
);

  localparam int B = BITS_PER_CHANNEL;

  pool_state_e           state;
  logic [COORD_BITS-1:0] x;
  logic [COORD_BITS-1:0] y;
  logic [B-1:0]          leak_q;
  logic [B-1:0]          thresh_q;
  logic [CHANNELS-1:0]   mask_q;
  logic [CHANNELS*B-1:0] v_new;
  logic [CHANNELS-1:0]   fire;
  logic                  last_coord;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    fm_leak_fire #(.B(B)) u_leak_fire (
      .v      (rd_data[i*B +: B]),
      .leak   (leak_q),
      .thresh (thresh_q),
      .v_new  (v_new[i*B +: B]),
      .fire   (fire[i])
    );
  end

  assign last_coord = (x == COORD_BITS'(IMG_WIDTH - 1)) && (y == COORD_BITS'(IMG_HEIGHT - 1));

  // Scan FSM; every interface output is a register written only here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_req    <= 1'b0;
      rd_coord  <= '0;
      wr_req    <= 1'b0;
      wr_coord  <= '0;
      wr_data   <= '0;
      evt_valid <= 1'b0;
      evt_coord <= '0;
      evt_mask  <= '0;
      mask_q    <= '0;
      leak_q    <= '0;
      thresh_q  <= '0;
      x         <= '0;
      y         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            leak_q   <= cfg_leak;
            thresh_q <= cfg_thresh;
            x        <= '0;
            y        <= '0;
            rd_req   <= 1'b1;
            rd_coord <= '0;
            state    <= READ;
          end
        end
        READ: begin
          if (rd_ready) begin
            rd_req <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          // Read data is only valid in this cycle, so capture the result now.
          wr_data  <= v_new;
          mask_q   <= fire;
          wr_coord <= rd_coord;
          wr_req   <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          if (wr_ready) begin
            wr_req <= 1'b0;
            if (mask_q != '0) begin
              evt_valid <= 1'b1;
              evt_coord <= wr_coord;
              evt_mask  <= mask_q;
              state     <= EMIT;
            end else begin
              state <= NEXT;
            end
          end
        end
        EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= NEXT;
          end
        end
        NEXT: begin
          if (last_coord) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (x == COORD_BITS'(IMG_WIDTH - 1)) begin
              x          <= '0;
              y          <= y + 1'b1;
              rd_coord.x <= '0;
              rd_coord.y <= y + 1'b1;
            end else begin
              x          <= x + 1'b1;
              rd_coord.x <= x + 1'b1;
              rd_coord.y <= y;
            end
            rd_req <= 1'b1;
            state  <= READ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FM_POOL_SPIKE_COUNT_EN
  localparam int SC_W = $clog2(IMG_WIDTH*IMG_HEIGHT*CHANNELS+1);

  logic [SC_W-1:0] mask_cnt;

  // Number of channels that fired at the coordinate being written back.
  always_comb begin
    mask_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mask_cnt = mask_cnt + SC_W'(mask_q[i]);
    end
  end

  // Spike total for the sweep, restarted by each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_count <= '0;
    end else if (state == IDLE && start) begin
      spike_count <= '0;
    end else if (state == WRITE && wr_ready) begin
      spike_count <= spike_count + mask_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fm_pool_scanner.sv
// Directed bench for fm_pool_scanner on a 4x4 map, 2 channels of 8 bits.
// A negedge responder models the arbiter ports and the event sink, with optional stalls.
// Build with FM_POOL_SPIKE_COUNT_EN defined to also check spike_count.
module tb_fm_pool_scanner;
  import snn_interfaces_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_leak = '0;
  logic [7:0]  cfg_thresh = '0;
  logic        busy, done;
  logic        rd_req;
  vec2_t       rd_coord;
  logic        rd_ready = 1'b1;
  logic [15:0] rd_data = '0;
  logic        wr_req;
  vec2_t       wr_coord;
  logic [15:0] wr_data;
  logic        wr_ready = 1'b1;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  vec2_t       evt_coord;
  logic [1:0]  evt_mask;
`ifdef FM_POOL_SPIKE_COUNT_EN
  logic [5:0]  spike_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [16];
  logic [15:0] wr_log_d [32];
  vec2_t       wr_log_c [32];
  vec2_t       ev_log_c [32];
  logic [1:0]  ev_log_m [32];
  int          nw = 0;
  int          ne = 0;
  int          rd_stall = 0;
  int          wr_stall = 0;
  int          evt_stall = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  fm_pool_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_leak   (cfg_leak),
    .cfg_thresh (cfg_thresh),
    .busy       (busy),
    .done       (done),
    .rd_req     (rd_req),
    .rd_coord   (rd_coord),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_coord   (wr_coord),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_coord  (evt_coord),
`ifdef FM_POOL_SPIKE_COUNT_EN
    .spike_count(spike_count),
`endif
    .evt_mask   (evt_mask)
  );

  // Arbiter and event-sink model: read data appears only in the cycle after a grant.
  initial begin : responder
    bit          rd_pend = 0;
    int          pend_idx = 0;
    bit          rd_hold = 0, wr_hold = 0, ev_hold = 0;
    vec2_t       rd_hc, wr_hc, ev_hc;
    logic [15:0] wr_hd;
    logic [1:0]  ev_hm;
    forever begin
      @(negedge clk);
      rd_data = rd_pend ? mem[pend_idx] : 16'hA5A5;
      if (rd_req && rd_stall > 0) begin
        rd_ready = 1'b0;
        rd_stall--;
        if (rd_hold) chk("rd_coord_held", rd_coord, rd_hc);
        else begin rd_hc = rd_coord; rd_hold = 1; end
      end else begin
        if (rd_hold) chk("rd_req_held", rd_req, 1'b1);
        rd_hold = 0;
        rd_ready = 1'b1;
      end
      rd_pend  = rd_req && rd_ready && !rst;
      pend_idx = int'(rd_coord.y) * 4 + int'(rd_coord.x);

      if (wr_req && wr_stall > 0) begin
        wr_ready = 1'b0;
        wr_stall--;
        if (wr_hold) begin
          chk("wr_data_held", wr_data, wr_hd);
          chk("wr_coord_held", wr_coord, wr_hc);
        end else begin wr_hd = wr_data; wr_hc = wr_coord; wr_hold = 1; end
      end else begin
        if (wr_hold) chk("wr_req_held", wr_req, 1'b1);
        wr_hold = 0;
        wr_ready = 1'b1;
        if (wr_req && nw < 32) begin
          wr_log_c[nw] = wr_coord;
          wr_log_d[nw] = wr_data;
          nw++;
        end
      end

      if (evt_valid && evt_stall > 0) begin
        evt_ready = 1'b0;
        evt_stall--;
        chk("no_rd_during_emit", rd_req, 1'b0);
        if (ev_hold) begin
          chk("evt_coord_held", evt_coord, ev_hc);
          chk("evt_mask_held", evt_mask, ev_hm);
        end else begin ev_hc = evt_coord; ev_hm = evt_mask; ev_hold = 1; end
      end else begin
        if (ev_hold) chk("evt_valid_held", evt_valid, 1'b1);
        ev_hold = 0;
        evt_ready = 1'b1;
        if (evt_valid && ne < 32) begin
          ev_log_c[ne] = evt_coord;
          ev_log_m[ne] = evt_mask;
          ne++;
        end
      end
    end
  end

  task automatic fill_mem(input logic [15:0] val);
    for (int i = 0; i < 16; i++) mem[i] = val;
  endtask

  // One sweep; optionally re-pulses start with different cfg while busy.
  task automatic run_sweep(input logic [7:0] leak, input logic [7:0] thr,
                           input bit poke, output int cyc);
    nw = 0;
    ne = 0;
    cfg_leak = leak;
    cfg_thresh = thr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 10) begin
        start = 1'b1;
        cfg_leak = 8'd0;
        cfg_thresh = 8'd0;
      end else begin
        start = 1'b0;
      end
    end
    chk("done_seen", done, 1'b1);
    chk("busy_with_done", busy, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  // Writes must come in raster order with the given data, one special coordinate.
  task automatic check_writes(input logic [15:0] dflt, input int sp_idx,
                              input logic [15:0] sp_val);
    vec2_t       ec;
    logic [15:0] ed;
    chk("write_count", nw, 16);
    for (int i = 0; i < nw && i < 16; i++) begin
      ec.x = 4'(i % 4);
      ec.y = 4'(i / 4);
      ed = (i == sp_idx) ? sp_val : dflt;
      chk("wr_coord_order", wr_log_c[i], ec);
      chk("wr_data_value", wr_log_d[i], ed);
    end
  endtask

  initial begin : main
    int    cyc;
    int    n;
    vec2_t ec;

    // Reset state
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_evt_valid", evt_valid, 1'b0);
    chk("rst_rd_coord", rd_coord, 8'h00);
    chk("rst_wr_data", wr_data, 16'h0000);
    chk("rst_evt_mask", evt_mask, 2'b00);
`ifdef FM_POOL_SPIKE_COUNT_EN
    chk("rst_spike_count", spike_count, 6'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1) all 10, leak 2, thresh 9: every write 8/8, no events, 4 cycles per coord
    fill_mem(16'h0A0A);
    run_sweep(8'd2, 8'd9, 1'b0, cyc);
    chk("s1_cycles", cyc, 65);
    check_writes(16'h0808, -1, 16'h0000);
    chk("s1_events", ne, 0);
`ifdef FM_POOL_SPIKE_COUNT_EN
    chk("s1_spike_count", spike_count, 6'd0);
`endif

    // 2) (1,2) = {ch1=5, ch0=20}, thresh 15; a start mid-sweep with new cfg is ignored
    fill_mem(16'h0A0A);
    mem[9] = 16'h0514;
    run_sweep(8'd2, 8'd15, 1'b1, cyc);
    chk("s2_cycles", cyc, 66);
    check_writes(16'h0808, 9, 16'h0300);
    chk("s2_events", ne, 1);
    ec.x = 4'd1;
    ec.y = 4'd2;
    chk("s2_evt_coord", ev_log_c[0], ec);
    chk("s2_evt_mask", ev_log_m[0], 2'b01);
`ifdef FM_POOL_SPIKE_COUNT_EN
    chk("s2_spike_count", spike_count, 6'd1);
`endif

    // 3a) v=1, leak 5, thresh 255: saturate to 0, a wrapped 252 would stay below 255
    fill_mem(16'h0101);
    run_sweep(8'd5, 8'd255, 1'b0, cyc);
    check_writes(16'h0000, -1, 16'h0000);
    chk("s3a_events", ne, 0);

    // 3b + 4) thresh 0: every coord fires both channels; first event stalled 10 cycles
    evt_stall = 10;
    run_sweep(8'd5, 8'd0, 1'b0, cyc);
    chk("s4_cycles", cyc, 91);
    chk("s4_stall_used", evt_stall, 0);
    check_writes(16'h0000, -1, 16'h0000);
    chk("s3b_events", ne, 16);
    n = 0;
    for (int i = 0; i < ne && i < 16; i++) begin
      ec.x = 4'(i % 4);
      ec.y = 4'(i / 4);
      if (ev_log_c[i] !== ec || ev_log_m[i] !== 2'b11) n++;
    end
    chk("s3b_event_list_bad", n, 0);
`ifdef FM_POOL_SPIKE_COUNT_EN
    chk("s3b_spike_count", spike_count, 6'd32);
`endif

    // 5) scenario 2 again with read stalled 7 and write stalled 3 cycles
    fill_mem(16'h0A0A);
    mem[9] = 16'h0514;
    rd_stall = 7;
    wr_stall = 3;
    run_sweep(8'd2, 8'd15, 1'b0, cyc);
    chk("s5_cycles", cyc, 76);
    check_writes(16'h0808, 9, 16'h0300);
    chk("s5_events", ne, 1);
    ec.x = 4'd1;
    ec.y = 4'd2;
    chk("s5_evt_coord", ev_log_c[0], ec);

    // 6) reset while reading (2,1), then a clean sweep from (0,0)
    fill_mem(16'h0A0A);
    cfg_leak = 8'd2;
    cfg_thresh = 8'd9;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(rd_req && rd_coord.x == 4'd2 && rd_coord.y == 4'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s6_reached_2_1", rd_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("s6_busy", busy, 1'b0);
    chk("s6_rd_req", rd_req, 1'b0);
    chk("s6_rd_coord", rd_coord, 8'h00);
    chk("s6_wr_req", wr_req, 1'b0);
    chk("s6_wr_coord", wr_coord, 8'h00);
    chk("s6_wr_data", wr_data, 16'h0000);
    chk("s6_evt_valid", evt_valid, 1'b0);
    chk("s6_evt_coord", evt_coord, 8'h00);
    chk("s6_evt_mask", evt_mask, 2'b00);
    chk("s6_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) n++;
    end
    chk("s6_no_done_after_rst", n, 0);
    run_sweep(8'd2, 8'd9, 1'b0, cyc);
    chk("s6_cycles", cyc, 65);
    check_writes(16'h0808, -1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
